// File: rtl/fpu_pkg.sv
// Shared FPU definitions: converter state encoding and IEEE-754 single constants.
package fpu_pkg;

  typedef enum logic [2:0] {
    GET_A,
    UNPACK,
    SPECIAL_CASES,
    SHIFT,
    PACK,
    PUT_Z
  } f2i_state_t;

  // Exponent bias, held at the 10-bit width of the unbiased exponent register.
  localparam logic [9:0]  FP_BIAS    = 10'd127;
  localparam logic [31:0] INT_MIN    = 32'h8000_0000;
  localparam logic [7:0]  FP_EXP_MAX = 8'd255;

endpackage

// File: rtl/float_to_int.sv
// IEEE-754 single to signed 32-bit integer, truncating toward zero.
// The mantissa is placed MSB-aligned in a 32-bit register and shifted right one bit
// per cycle until the binary point lands at bit 0, so the block costs one shifter.
// STB/BUSY handshake on both sides.
module float_to_int
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        f2i_input_STB,
  output logic        f2i_BUSY,
  output logic [31:0] output_z,
  output logic        f2i_output_STB,
  input  logic        output_module_BUSY
);

  f2i_state_t         state, state_next;
  logic [31:0]        a, a_next;
  logic               s, s_next;
  logic signed [9:0]  e, e_next;
  logic [31:0]        m, m_next;
  logic [4:0]         count, count_next;
  logic [31:0]        z, z_next;
  logic               busy_next;
  logic               stb_next;
  logic [31:0]        output_z_next;

  // Next-state and datapath decode; every register holds unless its state updates it.
  always_comb begin
    state_next    = state;
    a_next        = a;
    s_next        = s;
    e_next        = e;
    m_next        = m;
    count_next    = count;
    z_next        = z;
    busy_next     = f2i_BUSY;
    stb_next      = f2i_output_STB;
    output_z_next = output_z;

    case (state)
      GET_A: begin
        busy_next = 1'b0;
        if (!f2i_BUSY && f2i_input_STB) begin
          a_next     = input_a;
          busy_next  = 1'b1;
          state_next = UNPACK;
        end
      end

      UNPACK: begin
        s_next     = a[31];
        e_next     = $signed({2'b00, a[30:23]} - FP_BIAS);
        m_next     = {1'b1, a[22:0], 8'b0};
        state_next = SPECIAL_CASES;
      end

      SPECIAL_CASES: begin
        if (a[30:23] == FP_EXP_MAX && a[22:0] != 23'd0) begin
          z_next     = INT_MIN;
          state_next = PUT_Z;
        end else if (a[30:23] == FP_EXP_MAX || e > 10'sd30) begin
          // Out of range saturates to INT_MIN, which is also the exact answer for -2^31.
          z_next     = INT_MIN;
          state_next = PUT_Z;
        end else if (a[30:23] == 8'd0 || e < 10'sd0) begin
          // Zero, denormals and anything with magnitude below one truncate to zero.
          z_next     = 32'd0;
          state_next = PUT_Z;
        end else begin
          count_next = 5'(10'sd31 - e);
          state_next = SHIFT;
        end
      end

      SHIFT: begin
        if (count == 5'd0) begin
          state_next = PACK;
        end else begin
          m_next     = m >> 1;
          count_next = count - 5'd1;
        end
      end

      PACK: begin
        // Exponent at most 30 keeps m below 2^31, so negation cannot overflow.
        z_next     = s ? (~m + 32'd1) : m;
        state_next = PUT_Z;
      end

      PUT_Z: begin
        stb_next      = 1'b1;
        output_z_next = z;
        if (f2i_output_STB && !output_module_BUSY) begin
          stb_next   = 1'b0;
          state_next = GET_A;
        end
      end

      default: begin
        state_next = GET_A;
      end
    endcase
  end

  // State and datapath registers; reset only clears control so a pending result is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= GET_A;
      f2i_BUSY       <= 1'b0;
      f2i_output_STB <= 1'b0;
    end else begin
      state          <= state_next;
      f2i_BUSY       <= busy_next;
      f2i_output_STB <= stb_next;
      output_z       <= output_z_next;
      a              <= a_next;
      s              <= s_next;
      e              <= e_next;
      m              <= m_next;
      count          <= count_next;
      z              <= z_next;
    end
  end

`ifdef SYNTHESIS_OFF
  logic [103:0] state_name;

  // Readable state name for waveform viewing in simulation builds.
  always_comb begin
    state_name = "UNKNOWN";
    case (state)
      GET_A:         state_name = "GET_A";
      UNPACK:        state_name = "UNPACK";
      SPECIAL_CASES: state_name = "SPECIAL_CASES";
      SHIFT:         state_name = "SHIFT";
      PACK:          state_name = "PACK";
      PUT_Z:         state_name = "PUT_Z";
      default:       state_name = "UNKNOWN";
    endcase
  end
`endif

endmodule

// File: tb/tb_float_to_int.sv
// Directed bench for float_to_int: conversions, latency, backpressure and mid-shift reset.
module tb_float_to_int;

  logic        clk;
  logic        rst;
  logic [31:0] input_a;
  logic        f2i_input_STB;
  logic        f2i_BUSY;
  logic [31:0] output_z;
  logic        f2i_output_STB;
  logic        output_module_BUSY;

  int checks = 0;
  int errors = 0;

  float_to_int dut (
    .clk                (clk),
    .rst                (rst),
    .input_a            (input_a),
    .f2i_input_STB      (f2i_input_STB),
    .f2i_BUSY           (f2i_BUSY),
    .output_z           (output_z),
    .f2i_output_STB     (f2i_output_STB),
    .output_module_BUSY (output_module_BUSY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Wait for an idle converter, present one operand and return just after the acceptance edge.
  task automatic start_input(input logic [31:0] val);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (!f2i_BUSY && !f2i_output_STB) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL idle_wait: BUSY=%0b STB=%0b, required idle within 64 cycles", f2i_BUSY, f2i_output_STB);
    end
    input_a       = val;
    f2i_input_STB = 1'b1;
    @(posedge clk);
    #1;
    f2i_input_STB = 1'b0;
    checks++;
    if (f2i_BUSY !== 1'b1) begin
      errors++;
      $display("[TB] FAIL accept_busy: BUSY=%0b, required 1", f2i_BUSY);
    end
  endtask

  // Count edges after acceptance until STB is seen high; lat=0 signals a timeout.
  task automatic wait_result(output int lat);
    lat = 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (f2i_output_STB === 1'b1) begin
        lat = k;
        break;
      end
    end
    if (lat == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL result_timeout: STB never rose within 60 cycles");
    end
  endtask

  task automatic test_reset();
    rst                = 1'b1;
    input_a            = 32'd0;
    f2i_input_STB      = 1'b0;
    output_module_BUSY = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (f2i_BUSY !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_busy: got %0b, required 0", f2i_BUSY);
    end
    checks++;
    if (f2i_output_STB !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_stb: got %0b, required 0", f2i_output_STB);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_conversions();
    logic [31:0] vin [12];
    logic [31:0] vexp [12];
    int          vlat [12];
    int          lat;
    vin[0]  = 32'h3F80_0000; vexp[0]  = 32'h0000_0001; vlat[0]  = 36;  // 1.0
    vin[1]  = 32'hC020_0000; vexp[1]  = 32'hFFFF_FFFE; vlat[1]  = 35;  // -2.5
    vin[2]  = 32'h4EFF_FFFF; vexp[2]  = 32'h7FFF_FF80; vlat[2]  = 6;   // 2147483520
    vin[3]  = 32'h7FC0_0000; vexp[3]  = 32'h8000_0000; vlat[3]  = 3;   // NaN
    vin[4]  = 32'h7F80_0000; vexp[4]  = 32'h8000_0000; vlat[4]  = 3;   // +Inf
    vin[5]  = 32'h3F00_0000; vexp[5]  = 32'h0000_0000; vlat[5]  = 3;   // 0.5
    vin[6]  = 32'h8000_0000; vexp[6]  = 32'h0000_0000; vlat[6]  = 3;   // -0
    vin[7]  = 32'hFF80_0000; vexp[7]  = 32'h8000_0000; vlat[7]  = 3;   // -Inf
    vin[8]  = 32'h4F00_0000; vexp[8]  = 32'h8000_0000; vlat[8]  = 3;   // 2^31
    vin[9]  = 32'h0000_0001; vexp[9]  = 32'h0000_0000; vlat[9]  = 3;   // denormal
    vin[10] = 32'hBF80_0000; vexp[10] = 32'hFFFF_FFFF; vlat[10] = 36;  // -1.0
    vin[11] = 32'h4128_0000; vexp[11] = 32'h0000_000A; vlat[11] = 33;  // 10.5
    for (int i = 0; i < 12; i++) begin
      start_input(vin[i]);
      wait_result(lat);
      if (lat != 0) begin
        checks++;
        if (output_z !== vexp[i]) begin
          errors++;
          $display("[TB] FAIL conv_value[%0d]: in=%h got %h, required %h", i, vin[i], output_z, vexp[i]);
        end
        checks++;
        if (lat != vlat[i]) begin
          errors++;
          $display("[TB] FAIL conv_latency[%0d]: in=%h got %0d, required %0d", i, vin[i], lat, vlat[i]);
        end
        @(posedge clk);
        #1;
        checks++;
        if (f2i_output_STB !== 1'b0) begin
          errors++;
          $display("[TB] FAIL conv_stb_drop[%0d]: got %0b, required 0", i, f2i_output_STB);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    output_module_BUSY = 1'b1;
    start_input(32'h4120_0000);
    wait_result(lat);
    checks++;
    if (lat != 33) begin
      errors++;
      $display("[TB] FAIL bp_latency: got %0d, required 33", lat);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 3) begin
        input_a       = 32'h3F80_0000;
        f2i_input_STB = 1'b1;
      end else begin
        f2i_input_STB = 1'b0;
      end
      @(posedge clk);
      #1;
      checks++;
      if (f2i_output_STB !== 1'b1 || output_z !== 32'h0000_000A || f2i_BUSY !== 1'b1) begin
        errors++;
        $display("[TB] FAIL bp_hold[%0d]: STB=%0b z=%h BUSY=%0b, required 1 0000000a 1",
                 c, f2i_output_STB, output_z, f2i_BUSY);
      end
    end
    @(negedge clk);
    f2i_input_STB      = 1'b0;
    output_module_BUSY = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (f2i_output_STB !== 1'b0 || f2i_BUSY !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_release: STB=%0b BUSY=%0b, required 0 1", f2i_output_STB, f2i_BUSY);
    end
    @(posedge clk);
    #1;
    checks++;
    if (f2i_BUSY !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_busy_fall: BUSY=%0b, required 0", f2i_BUSY);
    end
    repeat (4) begin
      @(posedge clk);
      #1;
      checks++;
      if (f2i_output_STB !== 1'b0 || f2i_BUSY !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_not_queued: STB=%0b BUSY=%0b, required 0 0", f2i_output_STB, f2i_BUSY);
      end
    end
    start_input(32'h4040_0000);
    wait_result(lat);
    if (lat != 0) begin
      checks++;
      if (output_z !== 32'h0000_0003 || lat != 35) begin
        errors++;
        $display("[TB] FAIL bp_next: z=%h lat=%0d, required 00000003 35", output_z, lat);
      end
    end
  endtask

  task automatic test_reset_mid_shift();
    int lat;
    start_input(32'h3F80_0000);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (f2i_BUSY !== 1'b0 || f2i_output_STB !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_ctrl: BUSY=%0b STB=%0b, required 0 0", f2i_BUSY, f2i_output_STB);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (f2i_output_STB !== 1'b0 || f2i_BUSY !== 1'b0) begin
        checks++;
        errors++;
        $display("[TB] FAIL midreset_abandon: STB=%0b BUSY=%0b at cycle %0d, required 0 0",
                 f2i_output_STB, f2i_BUSY, c);
        break;
      end
    end
    start_input(32'h3F80_0000);
    wait_result(lat);
    if (lat != 0) begin
      checks++;
      if (output_z !== 32'h0000_0001 || lat != 36) begin
        errors++;
        $display("[TB] FAIL midreset_fresh: z=%h lat=%0d, required 00000001 36", output_z, lat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_conversions();
    test_backpressure();
    test_reset_mid_shift();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/float_to_int.md
# float_to_int

Converts an IEEE-754 single-precision value to a signed 32-bit two's-complement integer, truncating toward zero. It sits directly downstream of the FPU divider and takes `output_div` / `div_output_STB` as its input. It uses the same STB/BUSY handshake on both sides, so it can drop into any STB/BUSY chain. The conversion is iterative (one shift per cycle) to keep area small.

## Interface
- No parameters; widths fixed at 32 in / 32 out.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset; one clock; reset is synchronous and active-high.
- `input_a`  in  32  IEEE-754 single operand.
- `f2i_input_STB`  in  1  input valid.
- `f2i_BUSY`  out  1  block cannot accept; reset 0.
- `output_z`  out  32  signed integer result; don't-care after reset, then holds last valid result while STB low.
- `f2i_output_STB`  out  1  output valid; reset 0.
- `output_module_BUSY`  in  1  downstream cannot accept.

## Operation
- States: GET_A, UNPACK, SPECIAL_CASES, SHIFT, PACK, PUT_Z.
- GET_A
  - Drives `f2i_BUSY<=0`.
  - If `!f2i_BUSY && f2i_input_STB`: latches `a=input_a`, sets `f2i_BUSY<=1`, goes to UNPACK.
- UNPACK
  - `s=a[31]`, `e=a[30:23]-127` (10-bit signed), `m={1'b1,a[22:0],8'b0}` (32 bits).
- SPECIAL_CASES, evaluated in priority order:
  - NaN (`a[30:23]==255`, frac≠0): `z=32'h8000_0000`, go to PUT_Z.
  - ±Inf or `e>30` (out of range): `z=32'h8000_0000`, go to PUT_Z. This also covers -2^31, where the value is exact.
  - Zero or denormal (`a[30:23]==0`), or `e<0` (|x|<1): `z=0`, go to PUT_Z.
  - Otherwise: `count=31-e` (range 1..31), go to SHIFT.
- SHIFT
  - If `count==0`, go to PACK.
  - Else `m<=m>>1`, `count<=count-1`.
  - Discarded bits are dropped: no rounding, truncate toward zero.
- PACK
  - `z = s ? -m : m`, go to PUT_Z.
  - Result is never 0x8000_0000 here, because `e≤30` gives |m|<2^31.
- PUT_Z
  - `f2i_output_STB<=1`, `output_z<=z`.
  - If `f2i_output_STB && !output_module_BUSY`: `f2i_output_STB<=0`, go to GET_A.
- Reset dominates every state: `state=GET_A`, `f2i_BUSY=0`, `f2i_output_STB=0`.
  - Mid-operation reset abandons the result; no STB is issued for it.
- Inputs presented while BUSY=1 are ignored, not queued.

## Timing
- Edge 0 is the acceptance edge (GET_A with STB=1, BUSY=0). BUSY reads 1 after edge 0.
- Special-case path: UNPACK at edge 1, SPECIAL_CASES at edge 2, PUT_Z at edge 3. STB is high after edge 3, so latency is 3 cycles.
- Normal path: SHIFT occupies edges 3..3+count, PACK at edge 4+count, PUT_Z at edge 5+count.
  - STB is high after edge 5+count, so latency is 5+count.
  - Range: 6 cycles (e=30) to 36 cycles (e=0).
- Output handshake completes on the edge where STB=1 and `output_module_BUSY=0`. STB is low after that edge.
- BUSY falls one edge after the handshake (first GET_A cycle). The earliest next acceptance is the following edge, giving a 2-cycle gap between results.
- While `output_module_BUSY=1`, STB stays 1 and `output_z` stays stable indefinitely.

## Structure
- Shared package `fpu_pkg` holds:
  - state enum typedef `f2i_state_t`;
  - constants `FP_BIAS=127`, `INT_MIN=32'h8000_0000`, `FP_EXP_MAX=255`.
- Single module with no sub-module; the iterative shifter is inline in the FSM.
- A state-name debug register is added under the standard `SYNTHESIS_OFF` guard.

## Test plan
- `input_a=0x3F80_0000` (1.0), downstream ready → `output_z=0x0000_0001`, STB high 36 cycles after acceptance.
- `0xC020_0000` (-2.5) → `0xFFFF_FFFE` (-2, truncation).
- `0x4EFF_FFFF` (2147483520) → `0x7FFF_FF80`, latency 6 cycles.
- Special cases, each with latency 3:
  - `0x7FC0_0000` (NaN) → `0x8000_0000`;
  - `0x7F80_0000` (+Inf) → `0x8000_0000`;
  - `0x3F00_0000` (0.5) → `0`;
  - `0x8000_0000` (-0) → `0`.
- Backpressure on a converted `0x4120_0000` (10.0):
  - hold `output_module_BUSY=1` for 10 cycles → STB stays 1, `output_z=0x0000_000A` stable, BUSY stays 1;
  - a new `f2i_input_STB` in that window is ignored;
  - after release, STB falls, BUSY falls one cycle later, and the next input is accepted.
- Assert `rst` in SHIFT state → next cycle BUSY=0, STB=0, state GET_A; a fresh input of 1.0 then converts correctly.
